dual_port_ram_ctrl: RTL and testbench

Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2), as used for the character and pixel buffers of the VGA subsystem. Generalises the fixed 32-bit × 2048 dual-port buffer with:

- configurable width, depth and read latency;
- explicit `readdatavalid` and `waitrequest` per port;
- a hardware clear engine that fills the array with a programmable word after reset or on request;
- deterministic same-address write-collision arbitration with a saturating collision counter.

---
 rtl/dual_port_ram_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_dual_port_ram_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_ctrl.sv
//------------------------------------------------------------------------------
// Module  : dual_port_ram_ctrl
// Brief   : True-dual-port RAM behind two Avalon-MM slaves, with clear engine
//           and s1-wins write-collision arbitration. Optional macro
//           DUAL_PORT_RAM_BYPASS_EN forwards a mixed-port write to a read.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dual_port_ram_ctrl #(
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           ADDR_WIDTH     = 11,
   parameter int unsigned           READ_LATENCY   = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_WORD     = '0,
   parameter bit                    CLEAR_ON_RESET = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear_req,
   output logic                      clear_busy,
   output logic [15:0]               collision_count,
   input  logic [ADDR_WIDTH-1:0]     address1,
   input  logic [DATA_WIDTH/8-1:0]   byteenable1,
   input  logic                      chipselect1,
   input  logic                      read1,
   input  logic                      write1,
   input  logic                      clken1,
   input  logic [DATA_WIDTH-1:0]     writedata1,
   output logic [DATA_WIDTH-1:0]     readdata1,
   output logic                      readdatavalid1,
   output logic                      waitrequest1,
   input  logic [ADDR_WIDTH-1:0]     address2,
   input  logic [DATA_WIDTH/8-1:0]   byteenable2,
   input  logic                      chipselect2,
   input  logic                      read2,
   input  logic                      write2,
   input  logic                      clken2,
   input  logic [DATA_WIDTH-1:0]     writedata2,
   output logic [DATA_WIDTH-1:0]     readdata2,
   output logic                      readdatavalid2,
   output logic                      waitrequest2
);

   localparam int unsigned           BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned           DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [0:0]            ST_IDLE   = 1'b0;
   localparam logic [0:0]            ST_CLEAR  = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic                  tail_q, tail_d;
   logic                  w_clr_we;
   logic [15:0]           coll_cnt_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] w_addr   [2];
   logic [BE_WIDTH-1:0]   w_be     [2];
   logic [DATA_WIDTH-1:0] w_wdata  [2];
   logic [DATA_WIDTH-1:0] w_mask   [2];
   logic [DATA_WIDTH-1:0] w_merged [2];
   logic [DATA_WIDTH-1:0] w_rword  [2];
   logic [DATA_WIDTH-1:0] w_rdata  [2];
   logic [1:0]            w_cs, w_rd, w_wr, w_clken, w_wait, w_acc, w_we, w_re, w_rvalid;
   logic                  w_collide;

   assign w_addr[0]  = address1;
   assign w_addr[1]  = address2;
   assign w_be[0]    = byteenable1;
   assign w_be[1]    = byteenable2;
   assign w_wdata[0] = writedata1;
   assign w_wdata[1] = writedata2;
   assign w_cs       = {chipselect2, chipselect1};
   assign w_rd       = {read2, read1};
   assign w_wr       = {write2, write1};
   assign w_clken    = {clken2, clken1};

   // Clear engine FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         clr_addr_q <= '0;
         tail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         tail_q     <= tail_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      tail_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear_req) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end
         end
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (clr_addr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               tail_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // tail_q keeps busy high for the one cycle after the final clear write
   always_comb begin
      w_clr_we   = (state_q == ST_CLEAR) && !reset;
      clear_busy = reset ? CLEAR_ON_RESET : ((state_q == ST_CLEAR) || tail_q);
   end

   assign w_wait    = reset ? {2{CLEAR_ON_RESET}} : ({2{clear_busy}} | ~w_clken);
   assign w_acc     = w_cs & ~w_wait & {2{~reset}};
   assign w_collide = w_acc[0] & w_wr[0] & w_acc[1] & w_wr[1] & (w_addr[0] == w_addr[1]);
   assign w_we      = {w_acc[1] & w_wr[1] & ~w_collide, w_acc[0] & w_wr[0]};
   assign w_re      = w_acc & w_rd & ~w_wr;

   always_ff @(posedge clk) begin
      if (w_clr_we) mem_q[clr_addr_q] <= CLEAR_WORD;
      if (w_we[0])  mem_q[w_addr[0]]  <= w_merged[0];
      if (w_we[1])  mem_q[w_addr[1]]  <= w_merged[1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         coll_cnt_q <= '0;
      end else if (w_collide && (coll_cnt_q != 16'hFFFF)) begin
         coll_cnt_q <= coll_cnt_q + 16'd1;
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic                  w_stage_vld;
      logic [DATA_WIDTH-1:0] w_stage_data;
      logic                  rvalid_q;
      logic [DATA_WIDTH-1:0] rdata_q;

      for (genvar b = 0; b < BE_WIDTH; b++) begin : g_lane
         assign w_mask[p][8*b +: 8] = {8{w_be[p][b]}};
      end

      assign w_merged[p] = (mem_q[w_addr[p]] & ~w_mask[p]) | (w_wdata[p] & w_mask[p]);

`ifdef DUAL_PORT_RAM_BYPASS_EN
      // w_we of the other port already excludes a dropped s2 write
      assign w_rword[p] = (w_we[1-p] && (w_addr[1-p] == w_addr[p])) ? w_merged[1-p]
                                                                      : mem_q[w_addr[p]];
`else
      assign w_rword[p] = mem_q[w_addr[p]];
`endif

      if (READ_LATENCY == 2) begin : g_lat2
         logic                  pipe_vld_q;
         logic [DATA_WIDTH-1:0] pipe_data_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               pipe_vld_q  <= 1'b0;
               pipe_data_q <= '0;
            end else begin
               pipe_vld_q <= w_re[p];
               if (w_re[p]) pipe_data_q <= w_rword[p];
            end
         end
         assign w_stage_vld  = pipe_vld_q;
         assign w_stage_data = pipe_data_q;
      end else begin : g_lat1
         assign w_stage_vld  = w_re[p];
         assign w_stage_data = w_rword[p];
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
         end else begin
            rvalid_q <= w_stage_vld;
            if (w_stage_vld) rdata_q <= w_stage_data;
         end
      end

      assign w_rvalid[p] = rvalid_q;
      assign w_rdata[p]  = rdata_q;
   end

   assign collision_count = reset ? 16'd0 : coll_cnt_q;
   assign readdata1       = reset ? '0 : w_rdata[0];
   assign readdata2       = reset ? '0 : w_rdata[1];
   assign readdatavalid1  = ~reset & w_rvalid[0];
   assign readdatavalid2  = ~reset & w_rvalid[1];
   assign waitrequest1    = w_wait[0];
   assign waitrequest2    = w_wait[1];

endmodule

`default_nettype wire

// File: tb/tb_dual_port_ram_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_dual_port_ram_ctrl
// Brief   : Directed bench; dut A (latency 1, clear on reset) and dut B
//           (latency 2, no clear on reset) share all inputs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dual_port_ram_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int BW = 4;

`ifdef DUAL_PORT_RAM_BYPASS_EN
   localparam logic [31:0] BYP_EXP = 32'hA5A5A5A5;
`else
   localparam logic [31:0] BYP_EXP = 32'h00000000;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clear_req = 1'b0;
   logic [AW-1:0] address1 = '0, address2 = '0;
   logic [BW-1:0] byteenable1 = '0, byteenable2 = '0;
   logic          chipselect1 = 1'b0, chipselect2 = 1'b0;
   logic          read1 = 1'b0, read2 = 1'b0, write1 = 1'b0, write2 = 1'b0;
   logic          clken1 = 1'b1, clken2 = 1'b1;
   logic [DW-1:0] writedata1 = '0, writedata2 = '0;

   logic          a_clear_busy, b_clear_busy;
   logic [15:0]   a_collision_count, b_collision_count;
   logic [DW-1:0] a_readdata1, a_readdata2, b_readdata1, b_readdata2;
   logic          a_readdatavalid1, a_readdatavalid2, b_readdatavalid1, b_readdatavalid2;
   logic          a_waitrequest1, a_waitrequest2, b_waitrequest1, b_waitrequest2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dual_port_ram_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
      .CLEAR_WORD(32'h00000020), .CLEAR_ON_RESET(1'b1)
   ) u_dut_a (
      .clk(clk), .reset(reset), .clear_req(clear_req),
      .clear_busy(a_clear_busy), .collision_count(a_collision_count),
      .address1(address1), .byteenable1(byteenable1), .chipselect1(chipselect1),
      .read1(read1), .write1(write1), .clken1(clken1), .writedata1(writedata1),
      .readdata1(a_readdata1), .readdatavalid1(a_readdatavalid1), .waitrequest1(a_waitrequest1),
      .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
      .read2(read2), .write2(write2), .clken2(clken2), .writedata2(writedata2),
      .readdata2(a_readdata2), .readdatavalid2(a_readdatavalid2), .waitrequest2(a_waitrequest2)
   );

   dual_port_ram_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
      .CLEAR_WORD(32'h00000020), .CLEAR_ON_RESET(1'b0)
   ) u_dut_b (
      .clk(clk), .reset(reset), .clear_req(clear_req),
      .clear_busy(b_clear_busy), .collision_count(b_collision_count),
      .address1(address1), .byteenable1(byteenable1), .chipselect1(chipselect1),
      .read1(read1), .write1(write1), .clken1(clken1), .writedata1(writedata1),
      .readdata1(b_readdata1), .readdatavalid1(b_readdatavalid1), .waitrequest1(b_waitrequest1),
      .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
      .read2(read2), .write2(write2), .clken2(clken2), .writedata2(writedata2),
      .readdata2(b_readdata2), .readdatavalid2(b_readdatavalid2), .waitrequest2(b_waitrequest2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ports_idle();
      chipselect1 = 1'b0; read1 = 1'b0; write1 = 1'b0; byteenable1 = '0;
      chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0; byteenable2 = '0;
   endtask

   task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
      chipselect1 = 1'b1; write1 = 1'b1; address1 = a; writedata1 = d; byteenable1 = be;
      tick();
      ports_idle();
   endtask

   task automatic test_reset();
      int cnt;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({a_clear_busy, a_waitrequest1, a_waitrequest2} !== 3'b111) begin
         failures++; $display("FAIL rst_a_busy_wait got=%b exp=111", {a_clear_busy, a_waitrequest1, a_waitrequest2});
      end
      checks++;
      if ({b_clear_busy, b_waitrequest1, b_waitrequest2} !== 3'b000) begin
         failures++; $display("FAIL rst_b_busy_wait got=%b exp=000", {b_clear_busy, b_waitrequest1, b_waitrequest2});
      end
      checks++;
      if ({a_readdatavalid1, a_readdatavalid2, a_collision_count, a_readdata1, a_readdata2} !== '0) begin
         failures++; $display("FAIL rst_a_outputs got=%b/%b/%h/%h/%h exp=0", a_readdatavalid1, a_readdatavalid2,
                              a_collision_count, a_readdata1, a_readdata2);
      end
      @(posedge clk); #1 reset = 1'b0;
      cnt = 0;
      while (cnt < 100) begin
         @(negedge clk);
         if (!a_waitrequest1) break;
         cnt++;
      end
      checks++;
      if (cnt != 17) begin
         failures++; $display("FAIL rst_wait_cycles got=%0d exp=17", cnt);
      end
      checks++;
      if ({a_clear_busy, b_clear_busy} !== 2'b00) begin
         failures++; $display("FAIL post_clear_busy got=%b exp=00", {a_clear_busy, b_clear_busy});
      end
   endtask

   task automatic test_clear_contents();
      for (int a = 0; a < 16; a++) begin
         tick();
         chipselect1 = 1'b1; read1 = 1'b1; address1 = AW'(a);
         tick();
         ports_idle();
         @(negedge clk);
         checks++;
         if ({a_readdatavalid1, a_readdata1} !== {1'b1, 32'h00000020}) begin
            failures++; $display("FAIL clear_word a=%0d got=%b/%h exp=1/00000020", a, a_readdatavalid1, a_readdata1);
         end
      end
   endtask

   task automatic test_byteenable();
      tick();
      wr1(4'd5, 32'h00000000, 4'hF);
      wr1(4'd5, 32'hDEADBEEF, 4'b0101);
      chipselect2 = 1'b1; read2 = 1'b1; address2 = 4'd5;
      tick();
      ports_idle();
      @(negedge clk);
      checks++;
      if ({a_readdatavalid2, a_readdata2, b_readdatavalid2} !== {1'b1, 32'h00AD00EF, 1'b0}) begin
         failures++; $display("FAIL be_lat1 got=%b/%h bvalid=%b exp=1/00ad00ef bvalid=0",
                              a_readdatavalid2, a_readdata2, b_readdatavalid2);
      end
      @(negedge clk);
      checks++;
      if ({b_readdatavalid2, b_readdata2} !== {1'b1, 32'h00AD00EF}) begin
         failures++; $display("FAIL be_lat2 got=%b/%h exp=1/00ad00ef", b_readdatavalid2, b_readdata2);
      end
      checks++;
      if ({a_readdatavalid2, a_readdata2} !== {1'b0, 32'h00AD00EF}) begin
         failures++; $display("FAIL be_hold got=%b/%h exp=0/00ad00ef", a_readdatavalid2, a_readdata2);
      end
   endtask

   task automatic test_collision();
      tick();
      chipselect1 = 1'b1; write1 = 1'b1; address1 = 4'd3; writedata1 = 32'h11111111; byteenable1 = 4'hF;
      chipselect2 = 1'b1; write2 = 1'b1; address2 = 4'd3; writedata2 = 32'h22222222; byteenable2 = 4'hF;
      tick();
      ports_idle();
      @(negedge clk);
      checks++;
      if ({a_collision_count, b_collision_count} !== {16'd1, 16'd1}) begin
         failures++; $display("FAIL coll_count1 got=%h/%h exp=0001/0001", a_collision_count, b_collision_count);
      end
      tick();
      chipselect1 = 1'b1; read1 = 1'b1; address1 = 4'd3;
      tick();
      ports_idle();
      @(negedge clk);
      checks++;
      if ({a_readdatavalid1, a_readdata1} !== {1'b1, 32'h11111111}) begin
         failures++; $display("FAIL coll_s1_wins got=%b/%h exp=1/11111111", a_readdatavalid1, a_readdata1);
      end
      tick();
      chipselect1 = 1'b1; write1 = 1'b1; byteenable1 = 4'hF;
      chipselect2 = 1'b1; write2 = 1'b1; byteenable2 = 4'hF;
      repeat (99) tick();
      ports_idle();
      @(negedge clk);
      checks++;
      if (a_collision_count !== 16'd100) begin
         failures++; $display("FAIL coll_count100 got=%0d exp=100", a_collision_count);
      end
      tick();
      chipselect1 = 1'b1; write1 = 1'b1; byteenable1 = 4'hF;
      chipselect2 = 1'b1; write2 = 1'b1; byteenable2 = 4'hF;
      repeat (69900) tick();
      ports_idle();
      @(negedge clk);
      checks++;
      if (a_collision_count !== 16'hFFFF) begin
         failures++; $display("FAIL coll_saturate got=%h exp=ffff", a_collision_count);
      end
      // disjoint s2 lanes must still be dropped
      tick();
      chipselect1 = 1'b1; write1 = 1'b1; writedata1 = 32'h000000AA; byteenable1 = 4'b0001;
      chipselect2 = 1'b1; write2 = 1'b1; writedata2 = 32'hBBBBBBBB; byteenable2 = 4'b1110;
      tick();
      ports_idle();
      chipselect2 = 1'b1; read2 = 1'b1; address2 = 4'd3;
      tick();
      ports_idle();
      @(negedge clk);
      checks++;
      if ({a_readdatavalid2, a_readdata2} !== {1'b1, 32'h111111AA}) begin
         failures++; $display("FAIL coll_lanes got=%b/%h exp=1/111111aa", a_readdatavalid2, a_readdata2);
      end
      checks++;
      if (a_collision_count !== 16'hFFFF) begin
         failures++; $display("FAIL coll_hold got=%h exp=ffff", a_collision_count);
      end
   endtask

   task automatic test_bypass();
      tick();
      wr1(4'd7, 32'h00000000, 4'hF);
      chipselect1 = 1'b1; write1 = 1'b1; address1 = 4'd7; writedata1 = 32'hA5A5A5A5; byteenable1 = 4'hF;
      chipselect2 = 1'b1; read2 = 1'b1; address2 = 4'd7;
      tick();
      ports_idle();
      @(negedge clk);
      checks++;
      if ({a_readdatavalid2, a_readdata2} !== {1'b1, BYP_EXP}) begin
         failures++; $display("FAIL bypass_a got=%b/%h exp=1/%h", a_readdatavalid2, a_readdata2, BYP_EXP);
      end
      @(negedge clk);
      checks++;
      if ({b_readdatavalid2, b_readdata2} !== {1'b1, BYP_EXP}) begin
         failures++; $display("FAIL bypass_b got=%b/%h exp=1/%h", b_readdatavalid2, b_readdata2, BYP_EXP);
      end
      tick();
      chipselect1 = 1'b1; read1 = 1'b1; address1 = 4'd7;
      tick();
      ports_idle();
      @(negedge clk);
      checks++;
      if ({a_readdatavalid1, a_readdata1} !== {1'b1, 32'hA5A5A5A5}) begin
         failures++; $display("FAIL bypass_after got=%b/%h exp=1/a5a5a5a5", a_readdatavalid1, a_readdata1);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_rd [4];
      exp_rd = '{32'h00000020, 32'h00AD00EF, 32'h00000020, 32'hA5A5A5A5};
      tick();
      clken2 = 1'b0; chipselect2 = 1'b1; read2 = 1'b1; address2 = 4'd0;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            chipselect1 = 1'b1; read1 = 1'b1; address1 = AW'(4 + k);
         end else begin
            chipselect1 = 1'b0; read1 = 1'b0;
         end
         @(negedge clk);
         checks++;
         if ({a_waitrequest2, a_readdatavalid2} !== 2'b10) begin
            failures++; $display("FAIL clken_stall k=%0d got=%b exp=10", k, {a_waitrequest2, a_readdatavalid2});
         end
         if (k > 0) begin
            checks++;
            if ({a_readdatavalid1, a_readdata1} !== {1'b1, exp_rd[k-1]}) begin
               failures++; $display("FAIL b2b_read k=%0d got=%b/%h exp=1/%h", k, a_readdatavalid1, a_readdata1, exp_rd[k-1]);
            end
         end
         tick();
      end
      clken2 = 1'b1;
      ports_idle();
   endtask

   task automatic test_clear_abort();
      int cnt;
      tick();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      @(negedge clk);
      checks++;
      if (b_clear_busy !== 1'b1) begin
         failures++; $display("FAIL req_busy got=%b exp=1", b_clear_busy);
      end
      cnt = 0;
      while (cnt < 40) begin
         @(negedge clk);
         if (!b_clear_busy) break;
         cnt++;
      end
      checks++;
      if (cnt != 16) begin
         failures++; $display("FAIL req_sweep_len got=%0d exp=16", cnt);
      end
      tick();
      for (int a = 0; a < 16; a++) begin
         chipselect1 = 1'b1; write1 = 1'b1; address1 = AW'(a); writedata1 = 32'h100 + a; byteenable1 = 4'hF;
         tick();
      end
      ports_idle();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (10) tick();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({a_clear_busy, b_clear_busy, b_readdata1} !== {1'b1, 1'b0, 32'h0}) begin
         failures++; $display("FAIL abort_in_reset got=%b/%b/%h exp=1/0/00000000", a_clear_busy, b_clear_busy, b_readdata1);
      end
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({b_clear_busy, b_waitrequest1} !== 2'b00) begin
         failures++; $display("FAIL abort_busy got=%b exp=00", {b_clear_busy, b_waitrequest1});
      end
      for (int a = 0; a < 16; a++) begin
         logic [31:0] exp_w;
         if (a == 10) continue;
         exp_w = (a < 10) ? 32'h00000020 : 32'h100 + a;
         tick();
         chipselect1 = 1'b1; read1 = 1'b1; address1 = AW'(a);
         tick();
         ports_idle();
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({b_readdatavalid1, b_readdata1} !== {1'b1, exp_w}) begin
            failures++; $display("FAIL abort_contents a=%0d got=%b/%h exp=1/%h", a, b_readdatavalid1, b_readdata1, exp_w);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clear_contents();
      test_byteenable();
      test_collision();
      test_bypass();
      test_back_to_back();
      test_clear_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
